bcd_freq_meter_ctrl: RTL

BCD_FREQ_METER_CTRL -- requirements
Module: bcd_freq_meter_ctrl

---
 rtl/bcd_freq_meter_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bcd_freq_meter_ctrl.sv
// bcd_freq_meter_ctrl
//
// Gated event counter with a four-digit packed-BCD result. A measurement
// request loads a gate length N, clears the BCD chain, and counts the rising
// edges of event_in for exactly N cycles. It then latches the count into
// result/overflow and raises result_valid until the consumer acknowledges.
//
// Ports
//   clk          : clock, rising-edge active
//   reset        : asynchronous, active-high reset
//   start        : measurement request, only looked at while idle
//   gate_len     : gate length N in clk cycles, sampled together with start
//   event_in     : event signal, already synchronous to clk
//   result       : packed BCD count {d3,d2,d1,d0}, d0 least significant
//   overflow     : count went past 9999 during the reported measurement
//   result_valid : result/overflow hold a fresh measurement
//   result_ack   : consumer acknowledge, only looked at while holding
//   busy         : high whenever a measurement is in progress or held

module bcd_freq_meter_ctrl #(
    parameter int GATE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              event_in,
    output logic [15:0]       result,
    output logic              overflow,
    output logic              result_valid,
    input  logic              result_ack,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        GATE  = 3'd2,
        LATCH = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [15:0]       chain_q, chain_d;
    logic              chain_ovf_q, chain_ovf_d;
    logic [15:0]       result_q, result_d;
    logic              overflow_q, overflow_d;
    logic              valid_q, valid_d;
    logic              prev_q;

    logic              edge_det;
    logic [15:0]       chain_inc;
    logic              chain_carry;

    logic              start_ok;

    assign edge_det = event_in & ~prev_q;
    assign start_ok = start && (gate_len != '0);

    // BCD +1 on the whole chain: each digit at 9 wraps to 0 and passes the
    // carry on; a carry out of d3 means the chain went 9999 -> 0000.
    always_comb begin
        chain_inc   = chain_q;
        chain_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (chain_carry) begin
                if (chain_q[4*i +: 4] == 4'd9) begin
                    chain_inc[4*i +: 4] = 4'd0;
                end else begin
                    chain_inc[4*i +: 4] = chain_q[4*i +: 4] + 4'd1;
                    chain_carry         = 1'b0;
                end
            end
        end
    end

    // State register plus all datapath flops. The edge detector history is
    // updated in every state so an edge straddling a state change is seen
    // correctly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gate_cnt_q  <= '0;
            chain_q     <= '0;
            chain_ovf_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            valid_q     <= 1'b0;
            prev_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_cnt_q  <= gate_cnt_d;
            chain_q     <= chain_d;
            chain_ovf_q <= chain_ovf_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            valid_q     <= valid_d;
            prev_q      <= event_in;
        end
    end

    // Next-state logic. GATE leaves in the cycle the counter reads 1, which
    // gives exactly N gate cycles for a counter loaded with N.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = CLEAR;
            CLEAR:   state_d = GATE;
            GATE:    if (gate_cnt_q == GATE_W'(1)) state_d = LATCH;
            LATCH:   state_d = HOLD;
            HOLD:    if (result_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates per state. The latched result/overflow only change in
    // LATCH, so they persist through IDLE and the following CLEAR/GATE.
    always_comb begin
        gate_cnt_d  = gate_cnt_q;
        chain_d     = chain_q;
        chain_ovf_d = chain_ovf_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        valid_d     = valid_q;
        case (state_q)
            IDLE: begin
                if (start_ok) gate_cnt_d = gate_len;
            end
            CLEAR: begin
                chain_d     = '0;
                chain_ovf_d = 1'b0;
            end
            GATE: begin
                gate_cnt_d = gate_cnt_q - GATE_W'(1);
                if (edge_det) begin
                    chain_d = chain_inc;
                    if (chain_carry) chain_ovf_d = 1'b1;
                end
            end
            LATCH: begin
                result_d   = chain_q;
                overflow_d = chain_ovf_q;
                valid_d    = 1'b1;
            end
            HOLD: begin
                if (result_ack) valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Output decode. busy comes straight from the state so an asynchronous
    // reset drops it immediately.
    always_comb begin
        busy         = (state_q != IDLE);
        result       = result_q;
        overflow     = overflow_q;
        result_valid = valid_q;
    end

endmodule
